// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: shares one synchronous-FIFO write port among N_REQ requesters.
// Round-robin arbitration with a per-grant burst limit and valid/ready handshakes.
// Ports:
//   clk, rstn        clock, asynchronous active-low reset
//   i_req_valid      per-requester data valid
//   i_req_data       packed data, requester k at [k*DATA_W +: DATA_W]
//   o_req_ready      per-requester ready (one-hot or zero)
//   o_fifo_wren      FIFO write enable
//   o_fifo_wrdata    FIFO write data
//   i_fifo_full      FIFO full flag
//   o_grant_id       current or last granted requester
//   o_busy           high while a grant is active
module fifo_wr_arbiter #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned DATA_W    = 4,
  parameter int unsigned MAX_BURST = 4,
  localparam int unsigned ID_W     = $clog2(N_REQ),
  localparam int unsigned CNT_W    = $clog2(MAX_BURST + 1)
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [N_REQ-1:0]          i_req_valid,
  input  logic [N_REQ*DATA_W-1:0]   i_req_data,
  output logic [N_REQ-1:0]          o_req_ready,
  output logic                      o_fifo_wren,
  output logic [DATA_W-1:0]         o_fifo_wrdata,
  input  logic                      i_fifo_full,
  output logic [ID_W-1:0]           o_grant_id,
  output logic                      o_busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state, state_n;
  logic [ID_W-1:0]    gnt, gnt_n;
  logic [ID_W-1:0]    rr_ptr, rr_ptr_n;
  logic [CNT_W-1:0]   burst_cnt, burst_cnt_n;

  logic [ID_W-1:0]    win;
  logic               found;
  int unsigned        idx;
  logic               beat;
  logic               rel;
  logic               gnt_valid;
  logic [DATA_W-1:0]  gnt_data;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      gnt       <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_n;
      gnt       <= gnt_n;
      rr_ptr    <= rr_ptr_n;
      burst_cnt <= burst_cnt_n;
    end
  end

  // Round-robin scan: first valid index starting at rr_ptr, wrapping at N_REQ
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = (32'(rr_ptr) + i) % N_REQ;
      if (!found && i_req_valid[idx]) begin
        found = 1'b1;
        win   = ID_W'(idx);
      end
    end
  end

  assign gnt_valid = i_req_valid[gnt];
  assign gnt_data  = i_req_data[int'(gnt)*int'(DATA_W) +: DATA_W];

  // Next-state and handshake outputs
  always_comb begin
    state_n       = state;
    gnt_n         = gnt;
    rr_ptr_n      = rr_ptr;
    burst_cnt_n   = burst_cnt;
    o_req_ready   = '0;
    o_fifo_wren   = 1'b0;
    o_fifo_wrdata = '0;
    beat          = 1'b0;
    rel           = 1'b0;

    case (state)
      IDLE: begin
        if (found) begin
          gnt_n       = win;
          burst_cnt_n = '0;
          state_n     = GRANT;
        end
      end
      GRANT: begin
        o_req_ready[gnt] = !i_fifo_full;
        beat             = gnt_valid & !i_fifo_full;
        o_fifo_wren      = beat;
        o_fifo_wrdata    = gnt_data;
        // A full FIFO freezes the grant entirely, including a dropped valid.
        if (!i_fifo_full) begin
          if (beat) begin
            burst_cnt_n = burst_cnt + CNT_W'(1);
            rel         = (burst_cnt_n == CNT_W'(MAX_BURST));
          end else begin
            rel = 1'b1;
          end
        end
        if (rel) begin
          rr_ptr_n = (gnt == ID_W'(N_REQ - 1)) ? '0 : gnt + ID_W'(1);
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign o_grant_id = gnt;
  assign o_busy     = (state == GRANT);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter: directed vector table plus hand sequences for
// reset mid-burst and the all-valid fairness rotation.
module tb_fifo_wr_arbiter;

  localparam int unsigned N_REQ  = 4;
  localparam int unsigned DATA_W = 4;

  logic        clk;
  logic        rstn;
  logic [3:0]  i_req_valid;
  logic [15:0] i_req_data;
  logic [3:0]  o_req_ready;
  logic        o_fifo_wren;
  logic [3:0]  o_fifo_wrdata;
  logic        i_fifo_full;
  logic [1:0]  o_grant_id;
  logic        o_busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rstn;
    logic [3:0]  valid;
    logic [15:0] data;
    logic        full;
    logic [3:0]  ready;
    logic        wren;
    logic [3:0]  wrdata;
    logic [1:0]  gid;
    logic        busy;
  } vec_t;

  vec_t vq[$];

  fifo_wr_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .MAX_BURST(4)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .i_req_valid   (i_req_valid),
    .i_req_data    (i_req_data),
    .o_req_ready   (o_req_ready),
    .o_fifo_wren   (o_fifo_wren),
    .o_fifo_wrdata (o_fifo_wrdata),
    .i_fifo_full   (i_fifo_full),
    .o_grant_id    (o_grant_id),
    .o_busy        (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic add(input logic r, input logic [3:0] v, input logic [15:0] d, input logic f,
                     input logic [3:0] rdy, input logic we, input logic [3:0] wd,
                     input logic [1:0] g, input logic b);
    vec_t t;
    t.rstn = r; t.valid = v; t.data = d; t.full = f;
    t.ready = rdy; t.wren = we; t.wrdata = wd; t.gid = g; t.busy = b;
    vq.push_back(t);
  endtask

  task automatic drive(input logic r, input logic [3:0] v, input logic [15:0] d, input logic f);
    @(negedge clk);
    rstn = r; i_req_valid = v; i_req_data = d; i_fifo_full = f;
    #1;
  endtask

  initial begin
    rstn = 1'b0; i_req_valid = '0; i_req_data = '0; i_fifo_full = 1'b0;

    //   rstn valid  data      full  ready  wren wrdata gid busy
    // reset with arbitrary inputs, then release with no valid
    add(0, 4'hF, 16'h1234, 1, 4'h0, 0, 4'h0, 2'd0, 0);
    add(0, 4'h5, 16'hABCD, 0, 4'h0, 0, 4'h0, 2'd0, 0);
    add(1, 4'h0, 16'h0000, 0, 4'h0, 0, 4'h0, 2'd0, 0);
    add(1, 4'h0, 16'h0000, 0, 4'h0, 0, 4'h0, 2'd0, 0);
    // single requester 2, four beats A..D
    add(1, 4'h4, 16'h0A00, 0, 4'h0, 0, 4'h0, 2'd0, 0);
    add(1, 4'h4, 16'h0A00, 0, 4'h4, 1, 4'hA, 2'd2, 1);
    add(1, 4'h4, 16'h0B00, 0, 4'h4, 1, 4'hB, 2'd2, 1);
    add(1, 4'h4, 16'h0C00, 0, 4'h4, 1, 4'hC, 2'd2, 1);
    add(1, 4'h4, 16'h0D00, 0, 4'h4, 1, 4'hD, 2'd2, 1);
    add(1, 4'h0, 16'h0000, 0, 4'h0, 0, 4'h0, 2'd2, 0);
    // rr_ptr=3: requester 3 wins over 0, then drops valid after one beat
    add(1, 4'h9, 16'h0000, 0, 4'h0, 0, 4'h0, 2'd2, 0);
    add(1, 4'h9, 16'h1000, 0, 4'h8, 1, 4'h1, 2'd3, 1);
    add(1, 4'h1, 16'h2000, 0, 4'h8, 0, 4'h2, 2'd3, 1);
    // wrap to requester 0, which drops after one beat; requester 1 wins next
    add(1, 4'h1, 16'h0000, 0, 4'h0, 0, 4'h0, 2'd3, 0);
    add(1, 4'h3, 16'h0075, 0, 4'h1, 1, 4'h5, 2'd0, 1);
    add(1, 4'h2, 16'h0075, 0, 4'h1, 0, 4'h5, 2'd0, 1);
    add(1, 4'h3, 16'h0075, 0, 4'h0, 0, 4'h0, 2'd0, 0);
    // grant 1: two beats, five full cycles, two more beats, release
    add(1, 4'h2, 16'h0070, 0, 4'h2, 1, 4'h7, 2'd1, 1);
    add(1, 4'h2, 16'h0080, 0, 4'h2, 1, 4'h8, 2'd1, 1);
    for (int i = 0; i < 5; i++)
      add(1, 4'h2, 16'h0090, 1, 4'h0, 0, 4'h9, 2'd1, 1);
    add(1, 4'h2, 16'h0090, 0, 4'h2, 1, 4'h9, 2'd1, 1);
    add(1, 4'h2, 16'h00A0, 0, 4'h2, 1, 4'hA, 2'd1, 1);
    add(1, 4'h0, 16'h0000, 0, 4'h0, 0, 4'h0, 2'd1, 0);

    foreach (vq[k]) begin
      drive(vq[k].rstn, vq[k].valid, vq[k].data, vq[k].full);
      chk($sformatf("v%0d.ready", k),  16'(o_req_ready),   16'(vq[k].ready));
      chk($sformatf("v%0d.wren", k),   16'(o_fifo_wren),   16'(vq[k].wren));
      chk($sformatf("v%0d.wrdata", k), 16'(o_fifo_wrdata), 16'(vq[k].wrdata));
      chk($sformatf("v%0d.gid", k),    16'(o_grant_id),    16'(vq[k].gid));
      chk($sformatf("v%0d.busy", k),   16'(o_busy),        16'(vq[k].busy));
    end

    // Reset mid-burst: rr_ptr=2, so requester 2 is granted, reset on beat 2
    drive(1, 4'hF, 16'h4321, 0);
    chk("rm.idle_busy", 16'(o_busy), 16'd0);
    drive(1, 4'hF, 16'h4321, 0);
    chk("rm.beat1_wren", 16'(o_fifo_wren), 16'd1);
    chk("rm.beat1_gid", 16'(o_grant_id), 16'd2);
    chk("rm.beat1_data", 16'(o_fifo_wrdata), 16'd3);
    drive(0, 4'hF, 16'h4321, 0);
    chk("rm.rst_wren", 16'(o_fifo_wren), 16'd0);
    chk("rm.rst_ready", 16'(o_req_ready), 16'd0);
    chk("rm.rst_busy", 16'(o_busy), 16'd0);
    chk("rm.rst_gid", 16'(o_grant_id), 16'd0);
    chk("rm.rst_data", 16'(o_fifo_wrdata), 16'd0);

    // Fairness: after reset rotation starts at 0, 4 beats per grant, one idle between
    for (int n = 0; n < 12; n++) begin
      int g;
      g = n % 4;
      drive(1, 4'hF, 16'h4321, 0);
      chk($sformatf("rr%0d.idle_busy", n), 16'(o_busy), 16'd0);
      chk($sformatf("rr%0d.idle_wren", n), 16'(o_fifo_wren), 16'd0);
      for (int b = 0; b < 4; b++) begin
        drive(1, 4'hF, 16'h4321, 0);
        chk($sformatf("rr%0d.b%0d.gid", n, b), 16'(o_grant_id), 16'(g));
        chk($sformatf("rr%0d.b%0d.wren", n, b), 16'(o_fifo_wren), 16'd1);
        chk($sformatf("rr%0d.b%0d.ready", n, b), 16'(o_req_ready), 16'(1 << g));
        chk($sformatf("rr%0d.b%0d.data", n, b), 16'(o_fifo_wrdata), 16'(g + 1));
      end
    end
    drive(1, 4'h0, 16'h0000, 0);
    chk("end.busy", 16'(o_busy), 16'd0);
    chk("end.gid", 16'(o_grant_id), 16'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
